prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Synthesizable boot/program loader that replaces simulation-only memory and state initialisation of the CPU.
- Accepts a framed word stream over a valid/ready handshake and writes the payload into instruction ROM or data RAM. Checksums each frame.
- Holds the CPU in a not-running state until a START command arrives with no error.
- Sits between the external host/test source and the CPU's ROM and RAM write ports.

Parameters:
- DATA_WIDTH, 16, stream and memory word width; must be >= max(ROM_ADDR_WIDTH, RAM_ADDR_WIDTH) + 3.
- ROM_ADDR_WIDTH, 8, instruction ROM address width; depth is 2^ROM_ADDR_WIDTH.
- RAM_ADDR_WIDTH, 4, data RAM address width; depth is 2^RAM_ADDR_WIDTH.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  source presents in_data.
- in_data  in  DATA_WIDTH  stream word.
- in_ready  out  1  loader can accept a word; transfer occurs when in_valid && in_ready at a rising edge.
- rom_we  out  1  one-cycle ROM write strobe.
- rom_addr  out  ROM_ADDR_WIDTH  ROM write address.
- rom_wdata  out  DATA_WIDTH  ROM write data.
- ram_we  out  1  one-cycle RAM write strobe.
- ram_addr  out  RAM_ADDR_WIDTH  RAM write address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- cpu_run  out  1  CPU may execute; low holds the CPU in state 0 with pc=0.
- busy  out  1  a frame is in progress (DATA or CSUM state).
- error  out  1  sticky fault flag.
- error_code  out  2  01 checksum mismatch, 10 length overflow, 11 reserved opcode, 00 none.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clock, reset).
- Reset values:
  - State HDR; in_ready=1.
  - rom_we=0, ram_we=0; all addr/wdata=0.
  - cpu_run=0, busy=0, error=0, error_code=00.
  - Checksum accumulator=0, word counter=0.
- Reset mid-frame aborts the frame. Words already written stay in memory. No further strobes are issued.
- Header word fields:
  - op = in_data[DATA_WIDTH-1:DATA_WIDTH-2]: 00 ROM load, 01 RAM load, 10 START, 11 reserved.
  - len = in_data[DATA_WIDTH-3:0]; word count N = len+1.
- State HDR (in_ready=1), on an accepted word:
  - op 00/01 with N <= target depth: latch target and N; clear accumulator; address counter := 0; go to DATA.
  - op 00/01 with N > target depth: go to ERR, code 10.
  - op 10: go to RUN.
  - op 11: go to ERR, code 11.
- State DATA (in_ready=1), per accepted word:
  - Next cycle, the selected we pulses high for exactly 1 cycle with addr = counter and wdata = word.
  - Accumulator += word, mod 2^DATA_WIDTH.
  - Counter increments; after the Nth word go to CSUM.
  - Writes go to address 0..N-1 and never wrap within a frame.
- State CSUM (in_ready=1), on an accepted word:
  - Word equals accumulator: go to HDR.
  - Otherwise go to ERR, code 01.
- State RUN: in_ready=0; cpu_run=1 from the cycle after START is accepted; terminal until reset.
- State ERR: in_ready=0; error=1 and error_code held; cpu_run stays 0; terminal until reset.
- Stalls: in_valid low or gaps in any state produce no state change and no strobe.
- Latency: accepted data word to write strobe is 1 cycle. Back-to-back words give back-to-back strobes.
- Multiple frames may precede START, in any order and to either target. A later frame overwrites earlier contents.
- rom_we and ram_we are never high in the same cycle.
- busy=1 exactly while in DATA or CSUM.

Test Plan:
- ROM load: 0x0002, 0x1111, 0x2222, 0x3333, checksum 0x6666 -> rom_we pulses with addr 0/1/2, data 0x1111/0x2222/0x3333; returns to HDR; error=0.
- RAM load then START:
  - 0x4001, 0xFFFF, 0x0002, checksum 0x0001 (wrap) -> ram_we at addr 0/1.
  - Then 0x8000 -> cpu_run=1 the next cycle; in_ready=0; further in_valid is ignored.
- Bad checksum: 0x0000, 0x00AB, checksum 0x00AC -> one rom_we at addr 0; then error=1, code 01, cpu_run stays 0 after a subsequent 0x8000.
- Overflow and reserved opcode:
  - 0x4010 (N=17 > 16) -> error code 10 with no ram_we.
  - After reset, 0xC000 -> code 11.
- Backpressure and reset mid-frame:
  - ROM frame with in_valid low 3 cycles between words -> identical writes, no extra strobes.
  - Reset asserted after the 2nd data word -> all outputs at reset values next cycle.
  - A new 1-word frame then loads to addr 0.

Source files
------------

// File: rtl/prog_loader.sv
// Boot loader: takes framed words over valid/ready, writes payload into instruction ROM or
// data RAM with a per-frame checksum, and releases the CPU only after an error-free START.
//
// state | meaning
// HDR   | waiting for a frame header
// DATA  | receiving payload words, one write strobe per word
// CSUM  | waiting for the frame checksum word
// RUN   | START accepted, CPU released (terminal until reset)
// ERR   | fault latched, CPU held (terminal until reset)
module prog_loader #(
  parameter int DATA_WIDTH     = 16,
  parameter int ROM_ADDR_WIDTH = 8,
  parameter int RAM_ADDR_WIDTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      in_ready,
  output logic                      rom_we,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  output logic [DATA_WIDTH-1:0]     rom_wdata,
  output logic                      ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_wdata,
  output logic                      cpu_run,
  output logic                      busy,
  output logic                      error,
  output logic [1:0]                error_code
);

  localparam int LEN_W  = DATA_WIDTH - 2;
  localparam int ADDR_W = (ROM_ADDR_WIDTH > RAM_ADDR_WIDTH) ? ROM_ADDR_WIDTH : RAM_ADDR_WIDTH;
  localparam logic [LEN_W:0] ONE       = 1;
  localparam logic [LEN_W:0] ROM_DEPTH = ONE << ROM_ADDR_WIDTH;
  localparam logic [LEN_W:0] RAM_DEPTH = ONE << RAM_ADDR_WIDTH;

  typedef enum logic [2:0] {S_HDR, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;

  state_t                    state_q, state_d;
  logic                      tgt_ram_q, tgt_ram_d;
  logic [LEN_W-1:0]          rem_q, rem_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     acc_q, acc_d;
  logic [1:0]                code_d;
  logic                      rom_we_d, ram_we_d;
  logic [ROM_ADDR_WIDTH-1:0] rom_addr_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_d;
  logic [DATA_WIDTH-1:0]     rom_wdata_d, ram_wdata_d;

  logic             accept;
  logic [1:0]       op;
  logic [LEN_W-1:0] len;
  logic [LEN_W:0]   n_words;

  assign in_ready = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign busy     = (state_q == S_DATA) || (state_q == S_CSUM);
  assign cpu_run  = (state_q == S_RUN);
  assign error    = (state_q == S_ERR);
  assign accept   = in_valid && in_ready;
  assign op       = in_data[DATA_WIDTH-1:DATA_WIDTH-2];
  assign len      = in_data[LEN_W-1:0];
  assign n_words  = {1'b0, len} + ONE;

  always_comb begin
    state_d     = state_q;
    tgt_ram_d   = tgt_ram_q;
    rem_d       = rem_q;
    addr_d      = addr_q;
    acc_d       = acc_q;
    code_d      = error_code;
    rom_we_d    = 1'b0;
    ram_we_d    = 1'b0;
    rom_addr_d  = rom_addr;
    ram_addr_d  = ram_addr;
    rom_wdata_d = rom_wdata;
    ram_wdata_d = ram_wdata;
    case (state_q)
      S_HDR: begin
        if (accept) begin
          case (op)
            2'b00, 2'b01: begin
              if (n_words > ((op == 2'b01) ? RAM_DEPTH : ROM_DEPTH)) begin
                state_d = S_ERR;
                code_d  = 2'b10;
              end else begin
                state_d   = S_DATA;
                tgt_ram_d = op[0];
                rem_d     = len;
                addr_d    = '0;
                acc_d     = '0;
              end
            end
            2'b10:   state_d = S_RUN;
            default: begin
              state_d = S_ERR;
              code_d  = 2'b11;
            end
          endcase
        end
      end
      S_DATA: begin
        if (accept) begin
          acc_d  = acc_q + in_data;
          addr_d = addr_q + ADDR_W'(1);
          if (tgt_ram_q) begin
            ram_we_d    = 1'b1;
            ram_addr_d  = addr_q[RAM_ADDR_WIDTH-1:0];
            ram_wdata_d = in_data;
          end else begin
            rom_we_d    = 1'b1;
            rom_addr_d  = addr_q[ROM_ADDR_WIDTH-1:0];
            rom_wdata_d = in_data;
          end
          // rem_q holds words still expected minus one; zero marks the last payload word
          if (rem_q == '0) state_d = S_CSUM;
          else             rem_d   = rem_q - LEN_W'(1);
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (in_data == acc_q) begin
            state_d = S_HDR;
          end else begin
            state_d = S_ERR;
            code_d  = 2'b01;
          end
        end
      end
      S_RUN, S_ERR: ;
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_HDR;
      tgt_ram_q  <= 1'b0;
      rem_q      <= '0;
      addr_q     <= '0;
      acc_q      <= '0;
      error_code <= 2'b00;
      rom_we     <= 1'b0;
      ram_we     <= 1'b0;
      rom_addr   <= '0;
      ram_addr   <= '0;
      rom_wdata  <= '0;
      ram_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      tgt_ram_q  <= tgt_ram_d;
      rem_q      <= rem_d;
      addr_q     <= addr_d;
      acc_q      <= acc_d;
      error_code <= code_d;
      rom_we     <= rom_we_d;
      ram_we     <= ram_we_d;
      rom_addr   <= rom_addr_d;
      ram_addr   <= ram_addr_d;
      rom_wdata  <= rom_wdata_d;
      ram_wdata  <= ram_wdata_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed plan scenarios plus random multi-frame loads, checked against
// a frame-level model of expected writes (target, address, data, strobe cycle) and final status.
module tb_prog_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        rom_we, ram_we;
  logic [7:0]  rom_addr;
  logic [3:0]  ram_addr;
  logic [15:0] rom_wdata, ram_wdata;
  logic        cpu_run, busy, error;
  logic [1:0]  error_code;

  prog_loader #(.DATA_WIDTH(16), .ROM_ADDR_WIDTH(8), .RAM_ADDR_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .cpu_run(cpu_run), .busy(busy), .error(error), .error_code(error_code)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        ram;
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  wr_t  obs_q[$], exp_q[$];
  int   obs_cyc[$], exp_cyc[$];
  logic       exp_err, exp_run;
  logic [1:0] exp_code;

  always @(posedge clock) cyc <= cyc + 1;

  // observed write log; also enforces that the two strobes never overlap
  always @(negedge clock) begin
    if (rom_we || ram_we) begin
      n_checks++;
      if (rom_we && ram_we) begin
        n_fail++;
        $display("FAIL strobe_exclusive: rom_we=%b ram_we=%b, required not both high", rom_we, ram_we);
      end
      if (rom_we) obs_q.push_back('{1'b0, rom_addr, rom_wdata});
      else        obs_q.push_back('{1'b1, {4'h0, ram_addr}, ram_wdata});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = '0;
    reset    = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b0;
    obs_q.delete(); exp_q.delete(); obs_cyc.delete(); exp_cyc.delete();
    exp_err = 1'b0; exp_run = 1'b0; exp_code = 2'b00;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap, output int ac);
    int t = 0;
    ac = -1;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && t < 20) begin @(posedge clock); #1; t++; end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready=%b for word %h, required 1", in_ready, w);
      in_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    ac = cyc;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
  endtask

  task automatic drive_ignored(input logic [15:0] w, input int n);
    in_valid = 1'b1;
    in_data  = w;
    repeat (n) begin @(posedge clock); #1; end
    in_valid = 1'b0;
  endtask

  // sends one frame and records what the loader must do with it
  task automatic send_frame(input logic [1:0] op, input int len, input logic [15:0] pl[$],
                            input logic [15:0] csum, input int gap);
    int ac;
    int depth;
    logic [15:0] sum = 16'h0;
    send_word({op, 14'(len)}, gap, ac);
    if (op == 2'b10) begin exp_run = 1'b1; return; end
    if (op == 2'b11) begin exp_err = 1'b1; exp_code = 2'b11; return; end
    depth = (op == 2'b01) ? 16 : 256;
    if (len + 1 > depth) begin exp_err = 1'b1; exp_code = 2'b10; return; end
    for (int i = 0; i <= len; i++) begin
      send_word(pl[i], gap, ac);
      sum = sum + pl[i];
      exp_q.push_back('{op[0], 8'(i), pl[i]});
      exp_cyc.push_back(ac);
    end
    send_word(csum, gap, ac);
    if (csum != sum) begin exp_err = 1'b1; exp_code = 2'b01; end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF;
    repeat (2) begin @(posedge clock); #1; end
    n_checks++;
    if ({in_ready, busy, cpu_run, error, error_code} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_status: rdy/busy/run/err/code=%b, required 100000",
               {in_ready, busy, cpu_run, error, error_code});
    end
    n_checks++;
    if ({rom_we, ram_we, rom_addr, ram_addr, rom_wdata, ram_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_write_port: we=%b%b ra=%h wa=%h rd=%h wd=%h, required all zero",
               rom_we, ram_we, rom_addr, ram_addr, rom_wdata, ram_wdata);
    end
    do_reset();
  endtask

  task automatic test_rom_load();
    do_reset();
    send_frame(2'b00, 2, '{16'h1111, 16'h2222, 16'h3333}, 16'h6666, 0);
    repeat (2) begin @(posedge clock); #1; end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL rom_load_count: got %0d strobes, required %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i] || obs_cyc[i] !== exp_cyc[i]) begin
        n_fail++;
        $display("FAIL rom_load_write[%0d]: got %h @%0d, required %h @%0d", i, obs_q[i], obs_cyc[i], exp_q[i], exp_cyc[i]);
      end
    end
    n_checks++;
    if ({in_ready, busy, error, error_code, cpu_run} !== {1'b1, 1'b0, exp_err, exp_code, exp_run}) begin
      n_fail++;
      $display("FAIL rom_load_status: rdy/busy/err/code/run=%b%b%b%b%b, required 10%b%b%b",
               in_ready, busy, error, error_code, cpu_run, exp_err, exp_code, exp_run);
    end
  endtask

  task automatic test_ram_start();
    int ac;
    do_reset();
    send_frame(2'b01, 1, '{16'hFFFF, 16'h0002}, 16'h0001, 0);
    send_word(16'h8000, 0, ac);
    exp_run = 1'b1;
    n_checks++;
    if ({cpu_run, in_ready, error} !== 3'b100) begin
      n_fail++; $display("FAIL start_run: run/rdy/err=%b%b%b, required 100", cpu_run, in_ready, error);
    end
    drive_ignored(16'h0001, 6);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL ram_load_count: got %0d strobes, required %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i] || obs_cyc[i] !== exp_cyc[i]) begin
        n_fail++;
        $display("FAIL ram_load_write[%0d]: got %h @%0d, required %h @%0d", i, obs_q[i], obs_cyc[i], exp_q[i], exp_cyc[i]);
      end
    end
    n_checks++;
    if ({cpu_run, in_ready, busy, error} !== {exp_run, 3'b000}) begin
      n_fail++; $display("FAIL run_terminal: run/rdy/busy/err=%b%b%b%b, required 1000", cpu_run, in_ready, busy, error);
    end
  endtask

  task automatic test_bad_csum();
    do_reset();
    send_frame(2'b00, 0, '{16'h00AB}, 16'h00AC, 0);
    drive_ignored(16'h8000, 4);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL bad_csum_count: got %0d strobes, required %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bad_csum_write[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if ({error, error_code, cpu_run, in_ready} !== {exp_err, exp_code, exp_run, 1'b0}) begin
      n_fail++;
      $display("FAIL bad_csum_status: err/code/run/rdy=%b%b%b%b, required %b%b%b0",
               error, error_code, cpu_run, in_ready, exp_err, exp_code, exp_run);
    end
  endtask

  task automatic test_overflow_reserved();
    logic [15:0] pl[$];
    logic [15:0] s = 16'h0;
    do_reset();
    for (int i = 0; i < 16; i++) begin pl.push_back(16'(i * 16'h0101 + 7)); s = s + pl[i]; end
    send_frame(2'b01, 15, pl, s, 0);
    n_checks++;
    if ({error, busy, in_ready} !== 3'b001) begin
      n_fail++; $display("FAIL ram_full_depth: err/busy/rdy=%b%b%b, required 001", error, busy, in_ready);
    end
    send_frame(2'b01, 16, pl, 16'h0, 0);
    repeat (3) begin @(posedge clock); #1; end
    n_checks++;
    if (obs_q.size() !== 16 || {error, error_code} !== {exp_err, exp_code}) begin
      n_fail++;
      $display("FAIL ram_overflow: strobes=%0d err=%b code=%b, required 16 %b %b",
               obs_q.size(), error, error_code, exp_err, exp_code);
    end
    do_reset();
    send_frame(2'b00, 256, pl, 16'h0, 0);
    @(posedge clock); #1;
    n_checks++;
    if (obs_q.size() !== 0 || {error, error_code} !== {exp_err, exp_code}) begin
      n_fail++;
      $display("FAIL rom_overflow: strobes=%0d err=%b code=%b, required 0 %b %b",
               obs_q.size(), error, error_code, exp_err, exp_code);
    end
    do_reset();
    send_frame(2'b11, 0, pl, 16'h0, 0);
    @(posedge clock); #1;
    n_checks++;
    if ({error, error_code, cpu_run, in_ready} !== {exp_err, exp_code, 2'b00}) begin
      n_fail++;
      $display("FAIL reserved_op: err/code/run/rdy=%b%b%b%b, required %b%b00",
               error, error_code, cpu_run, in_ready, exp_err, exp_code);
    end
  endtask

  task automatic test_backpressure_reset();
    int ac;
    do_reset();
    send_frame(2'b00, 2, '{16'hA001, 16'hB002, 16'hC003}, 16'h1006, 3);
    repeat (2) begin @(posedge clock); #1; end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL gap_count: got %0d strobes, required %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i] || obs_cyc[i] !== exp_cyc[i]) begin
        n_fail++;
        $display("FAIL gap_write[%0d]: got %h @%0d, required %h @%0d", i, obs_q[i], obs_cyc[i], exp_q[i], exp_cyc[i]);
      end
    end
    n_checks++;
    if ({error, error_code} !== {exp_err, exp_code}) begin
      n_fail++; $display("FAIL gap_status: err=%b code=%b, required %b %b", error, error_code, exp_err, exp_code);
    end

    do_reset();
    send_word(16'h0003, 0, ac);
    send_word(16'h1234, 0, ac);
    send_word(16'h5678, 0, ac);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_frame_busy: busy=%b, required 1", busy);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if ({in_ready, busy, cpu_run, error, error_code, rom_we, ram_we, rom_addr, rom_wdata} !== {1'b1, 31'h0}) begin
      n_fail++;
      $display("FAIL mid_frame_reset: rdy/busy/run/err=%b%b%b%b code=%b we=%b%b addr=%h data=%h, required 1000 00 00 00 0000",
               in_ready, busy, cpu_run, error, error_code, rom_we, ram_we, rom_addr, rom_wdata);
    end
    n_checks++;
    if (obs_q.size() !== 2) begin
      n_fail++; $display("FAIL mid_frame_strobes: got %0d strobes, required 2", obs_q.size());
    end
    do_reset();
    send_frame(2'b00, 0, '{16'h5A5A}, 16'h5A5A, 0);
    repeat (2) begin @(posedge clock); #1; end
    n_checks++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0] || error !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_after_reset: strobes=%0d first=%h err=%b, required 1 %h 0",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : wr_t'(0), error, exp_q[0]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int nfr;
      do_reset();
      nfr = $urandom_range(1, 4);
      for (int f = 0; f < nfr && !exp_err; f++) begin
        logic [15:0] pl[$];
        logic [15:0] s = 16'h0;
        logic [1:0]  op = 2'($urandom_range(0, 1));
        int len;
        int r = $urandom_range(0, 9);
        if (op == 2'b01) len = (r == 0) ? 16 : ((r == 1) ? 15 : $urandom_range(0, 7));
        else             len = (r == 0) ? 300 : $urandom_range(0, 9);
        for (int i = 0; i <= len && i < 32; i++) begin pl.push_back(16'($urandom)); s = s + pl[i]; end
        if ($urandom_range(0, 5) == 0) s = s ^ 16'h0100;
        send_frame(op, len, pl, s, $urandom_range(0, 2));
      end
      if (!exp_err && $urandom_range(0, 1) == 1) send_frame(2'b10, 0, '{16'h0}, 16'h0, 0);
      if (exp_err || exp_run) drive_ignored(16'($urandom), 3);
      repeat (2) begin @(posedge clock); #1; end
      n_checks++;
      if (obs_q.size() !== exp_q.size()) begin
        n_fail++; $display("FAIL random_count[%0d]: got %0d strobes, required %0d", it, obs_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i] || obs_cyc[i] !== exp_cyc[i]) begin
          n_fail++;
          $display("FAIL random_write[%0d.%0d]: got %h @%0d, required %h @%0d", it, i, obs_q[i], obs_cyc[i], exp_q[i], exp_cyc[i]);
        end
      end
      n_checks++;
      if ({error, error_code, cpu_run, busy} !== {exp_err, exp_code, exp_run, 1'b0}) begin
        n_fail++;
        $display("FAIL random_status[%0d]: err/code/run/busy=%b%b%b%b, required %b%b%b0",
                 it, error, error_code, cpu_run, busy, exp_err, exp_code, exp_run);
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    exp_err = 1'b0; exp_run = 1'b0; exp_code = 2'b00;
    test_reset();
    test_rom_load();
    test_ram_start();
    test_bad_csum();
    test_overflow_reserved();
    test_backpressure_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
